// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It merges load-use, branch flush and the mult/div busy window.
// Latency: stall and flush outputs are combinational, in the same cycle as the request. md_busy is registered state.
// Backpressure: flush overrides the mult/div stall, which overrides the load stall. A blocked md_start_ID is dropped and re-presented later.
module pipeline_stall_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_hazard,
  input  logic        branch_taken_EXE,
  input  logic        md_start_ID,
  input  logic        md_is_div,
  input  logic        md_use_ID,
  output logic        PC_stall,
  output logic        IF_stall,
  output logic        ID_stall,
  output logic        EXE_bubble,
  output logic        IF_flush,
  output logic        ID_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_count
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  // Counter preload: the op completes in the cycle where the counter reaches zero.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_count_q, stall_count_d;

  logic in_wait;
  logic cnt_zero;
  logic flush;
  logic md_stall;
  logic ld_stall;
  logic stall;

  // Hazard arbitration. Flush wins outright because the younger instructions are being discarded anyway.
  always_comb begin
    in_wait  = (state_q == MD_WAIT);
    cnt_zero = (cnt_q == '0);
    flush    = branch_taken_EXE;
    md_stall = in_wait && !cnt_zero && md_use_ID && !flush;
    ld_stall = load_hazard && !flush;
    stall    = md_stall || ld_stall;
  end

  // Per-stage controls. Outputs are forced low while reset is held, so the pipeline sees a clean idle state.
  always_comb begin
    PC_stall    = stall && !rst;
    IF_stall    = stall && !rst;
    ID_stall    = stall && !rst;
    EXE_bubble  = stall && !rst;
    IF_flush    = flush && !rst;
    ID_flush    = flush && !rst;
    md_busy     = in_wait;
    md_done     = in_wait && cnt_zero;
    stall_count = stall_count_q;
  end

  // Next-state logic for the mult/div window and the saturating stall counter.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;

    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end

    case (state_q)
      RUN: begin
        // A stalled or flushed mult/div is not issued. The same instruction comes back later.
        if (md_start_ID && !stall && !flush) begin
          state_d = MD_WAIT;
          cnt_d   = md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_WAIT: begin
        // A branch flush does not touch the window, because the in-flight op is older than the branch.
        // A new mult/div seen here is only a dependent use and does not reload the counter.
        if (cnt_zero) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a vector table plus hand-built multi-cycle sequences.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked on the falling edge.
// Expected values are hand-computed, or come from a small running stall-count model.
module tb_pipeline_stall_controller;

  logic        clk;
  logic        rst;
  logic        load_hazard;
  logic        branch_taken_EXE;
  logic        md_start_ID;
  logic        md_is_div;
  logic        md_use_ID;
  logic        PC_stall;
  logic        IF_stall;
  logic        ID_stall;
  logic        EXE_bubble;
  logic        IF_flush;
  logic        ID_flush;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_count;

  int n_vec  = 0;
  int n_fail = 0;

  pipeline_stall_controller #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_hazard     (load_hazard),
    .branch_taken_EXE(branch_taken_EXE),
    .md_start_ID     (md_start_ID),
    .md_is_div       (md_is_div),
    .md_use_ID       (md_use_ID),
    .PC_stall        (PC_stall),
    .IF_stall        (IF_stall),
    .ID_stall        (ID_stall),
    .EXE_bubble      (EXE_bubble),
    .IF_flush        (IF_flush),
    .ID_flush        (ID_flush),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit order: {PC_stall, IF_stall, ID_stall, EXE_bubble, IF_flush, ID_flush, md_busy, md_done}
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_STALL = 8'b1111_0000;
  localparam logic [7:0] O_FLUSH = 8'b0000_1100;
  localparam logic [7:0] O_MDSTL = 8'b1111_0010;
  localparam logic [7:0] O_BUSY  = 8'b0000_0010;
  localparam logic [7:0] O_DONE  = 8'b0000_0011;
  localparam logic [7:0] O_MDFL  = 8'b0000_1110;

  // Input bit order: {rst, load_hazard, branch_taken_EXE, md_start_ID, md_is_div, md_use_ID}
  typedef struct {
    logic [5:0]  in;
    logic [7:0]  exp_o;
    logic [15:0] exp_sc;
  } vec_t;

  vec_t tbl[24];

  function automatic logic [7:0] outs();
    return {PC_stall, IF_stall, ID_stall, EXE_bubble, IF_flush, ID_flush, md_busy, md_done};
  endfunction

  task automatic drive(input logic [5:0] in);
    {rst, load_hazard, branch_taken_EXE, md_start_ID, md_is_div, md_use_ID} = in;
  endtask

  task automatic check(input string tag, input logic [7:0] eo, input logic [15:0] esc);
    n_vec++;
    if (outs() !== eo || stall_count !== esc) begin
      n_fail++;
      $display("FAIL %s: got outs=%b stall_count=%0d, expected outs=%b stall_count=%0d",
               tag, outs(), stall_count, eo, esc);
    end
  endtask

  // Each call covers one clock cycle. The bench is at edge+1 on entry and again on exit.
  task automatic run_cycle(input string tag, input logic [5:0] in, input logic [7:0] eo,
                           input logic [15:0] esc);
    drive(in);
    @(negedge clk);
    check(tag, eo, esc);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_sc;
  logic [7:0]  eo;

  initial begin
    // Reset, load-use, mult with a dependent use, flush in RUN, start blocked by a load, and flush inside MD_WAIT.
    tbl[0]  = '{6'b100000, O_IDLE,  16'd0};  // reset held
    tbl[1]  = '{6'b000000, O_IDLE,  16'd0};  // idle RUN
    tbl[2]  = '{6'b010000, O_STALL, 16'd0};  // load-use, 1 cycle
    tbl[3]  = '{6'b000000, O_IDLE,  16'd1};
    tbl[4]  = '{6'b000101, O_IDLE,  16'd1};  // mult issue (E0)
    tbl[5]  = '{6'b000001, O_MDSTL, 16'd1};  // cycle 1
    tbl[6]  = '{6'b000001, O_MDSTL, 16'd2};  // cycle 2
    tbl[7]  = '{6'b000001, O_MDSTL, 16'd3};  // cycle 3
    tbl[8]  = '{6'b000001, O_DONE,  16'd4};  // cycle 4: done, no stall
    tbl[9]  = '{6'b000001, O_IDLE,  16'd4};  // back in RUN
    tbl[10] = '{6'b011000, O_FLUSH, 16'd4};  // flush beats load stall
    tbl[11] = '{6'b000000, O_IDLE,  16'd4};
    tbl[12] = '{6'b010101, O_STALL, 16'd4};  // start + load: blocked
    tbl[13] = '{6'b000101, O_IDLE,  16'd5};  // load dropped: issue
    tbl[14] = '{6'b000101, O_MDSTL, 16'd5};  // start in MD_WAIT is a dependent use
    tbl[15] = '{6'b000101, O_MDSTL, 16'd6};
    tbl[16] = '{6'b000101, O_MDSTL, 16'd7};
    tbl[17] = '{6'b000101, O_DONE,  16'd8};  // counter from MULT_CYCLES-1; start not accepted here
    tbl[18] = '{6'b000101, O_IDLE,  16'd8};  // issues from RUN
    tbl[19] = '{6'b000000, O_BUSY,  16'd8};  // busy, no use: no stall
    tbl[20] = '{6'b001001, O_MDFL,  16'd8};  // flush in MD_WAIT
    tbl[21] = '{6'b000001, O_MDSTL, 16'd8};  // counter unaffected by flush
    tbl[22] = '{6'b000001, O_DONE,  16'd9};
    tbl[23] = '{6'b000000, O_IDLE,  16'd9};

    drive(6'b100000);
    #2;
    check("reset_async_initial", O_IDLE, 16'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      run_cycle($sformatf("tbl[%0d]", i), tbl[i].in, tbl[i].exp_o, tbl[i].exp_sc);
    end

    // Div with a branch in cycle 10 and a dependent use throughout.
    exp_sc = 16'd9;
    run_cycle("div_issue", 6'b000111, O_IDLE, exp_sc);
    for (int c = 1; c <= 32; c++) begin
      if (c == 32)      eo = O_DONE;
      else if (c == 10) eo = O_MDFL;
      else              eo = O_MDSTL;
      run_cycle($sformatf("div_c%0d", c), (c == 10) ? 6'b001001 : 6'b000001, eo, exp_sc);
      if (eo == O_MDSTL) exp_sc = exp_sc + 16'd1;
    end
    run_cycle("div_after", 6'b000001, O_IDLE, exp_sc);

    // Reset asserted mid-div, between clock edges.
    run_cycle("rst_div_issue", 6'b000111, O_IDLE, exp_sc);
    for (int c = 1; c <= 9; c++) begin
      run_cycle($sformatf("rst_div_c%0d", c), 6'b000001, O_MDSTL, exp_sc);
      exp_sc = exp_sc + 16'd1;
    end
    drive(6'b100001);
    #1;
    check("rst_mid_op_immediate", O_IDLE, 16'd0);
    @(negedge clk);
    check("rst_mid_op_held", O_IDLE, 16'd0);
    @(posedge clk);
    #1;
    run_cycle("rst_release_idle", 6'b000001, O_IDLE, 16'd0);

    // Saturation: a long load-use stall.
    exp_sc = 16'd0;
    for (int i = 0; i < 65540; i++) begin
      drive(6'b010000);
      @(negedge clk);
      if ((i % 8192) == 0 || i >= 65533) check($sformatf("sat_%0d", i), O_STALL, exp_sc);
      if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      @(posedge clk);
      #1;
    end
    run_cycle("sat_hold", 6'b000000, O_IDLE, 16'hFFFF);
    run_cycle("sat_hold2", 6'b000000, O_IDLE, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges the load-use stall request from the hazard detection unit, the branch-taken flush from EXE, and the busy window of the multi-cycle multiply/divide unit. Produces per-stage stall, bubble and flush controls. Owns the mult/div cycle counter and a saturating stall-cycle performance counter.

Parameters:
MULT_CYCLES, 4, cycles from mult issue to result valid (>=1)
DIV_CYCLES, 32, cycles from div issue to result valid (>=1)
CNT_W, 6, mult/div counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous reset, active-high
load_hazard  input  1  load-use hazard request from hazard detection unit
branch_taken_EXE  input  1  taken branch/jump resolved in EXE
md_start_ID  input  1  ID-stage instruction is mult/multu/div/divu
md_is_div  input  1  qualifies md_start_ID: 1=div, 0=mult
md_use_ID  input  1  ID-stage instruction reads HI/LO or is mult/div
PC_stall  output  1  hold PC
IF_stall  output  1  hold IF/ID register
ID_stall  output  1  hold ID-stage instruction
EXE_bubble  output  1  load NOP into ID/EXE register
IF_flush  output  1  clear IF/ID register
ID_flush  output  1  clear ID/EXE register
md_busy  output  1  mult/div in progress (registered state)
md_done  output  1  one-cycle pulse: HI/LO result valid this cycle
stall_count  output  16  saturating count of cycles with PC_stall=1

Behaviour:
- Reset (async, any time incl. mid-operation): state=RUN, counter=0, stall_count=0. All outputs 0.
- States: RUN, MD_WAIT. md_busy = (state==MD_WAIT).
- Stall/flush outputs are combinational from state, counter and inputs. They take effect in the same cycle as the request.
- Priority: flush > mult/div stall > load stall.
- flush = branch_taken_EXE. Drives IF_flush=ID_flush=1, and PC_stall=IF_stall=ID_stall=EXE_bubble=0 that cycle.
- md_stall = (state==MD_WAIT) && (counter!=0) && md_use_ID && !flush.
- ld_stall = load_hazard && !flush.
- stall = md_stall || ld_stall. Drives PC_stall=IF_stall=ID_stall=EXE_bubble=1.
- RUN -> MD_WAIT at the clock edge where md_start_ID && !stall && !flush. Counter loads (md_is_div ? DIV_CYCLES : MULT_CYCLES)-1.
  - md_start_ID is ignored if stalled or flushed that cycle; the instruction re-presents later.
- MD_WAIT behaviour:
  - Counter decrements by 1 per cycle.
  - While counter==0: md_done=1 for that cycle, md_stall=0, and next state is RUN.
  - Latency: issue edge E0 -> md_done high in the Nth cycle after E0 (N = MULT_CYCLES or DIV_CYCLES).
  - md_busy stays high through the md_done cycle.
- In MD_WAIT, md_start_ID is a dependent use: it stalls via md_use_ID and does not reload the counter.
  - In the md_done cycle a new md_start_ID is not accepted; it issues the following cycle from RUN.
- Flush in MD_WAIT does not affect the counter or state; the in-flight op is older than the branch.
- MULT_CYCLES=1: counter loads 0, md_done in the first MD_WAIT cycle, no md_stall ever.
- stall_count increments at each edge where PC_stall=1. It holds at 16'hFFFF and never wraps.
- No other internal state. Load stalls carry no state and last exactly as long as load_hazard is high.

Test Plan:
1. Reset mid-op: issue div, assert rst at cycle 10 -> md_busy, md_done, stall_count and all stall/flush outputs 0 immediately (before next edge). After release, idle RUN.
2. Load-use: load_hazard=1 for 1 cycle in RUN -> PC_stall/IF_stall/ID_stall/EXE_bubble=1 that cycle only. stall_count=1 afterwards.
3. Mult with dependent mfhi: md_start_ID=1, md_is_div=0 at E0, then md_use_ID=1 held -> md_busy 4 cycles. Stall outputs high cycles 1-3, low in cycle 4 where md_done=1. stall_count=3. RUN in cycle 5.
4. Div plus branch: div issued at E0, branch_taken_EXE=1 in cycle 10, md_use_ID=1 throughout:
   - cycle 10: IF_flush=ID_flush=1, stalls=0.
   - cycles 1-9 and 11-31: stalled.
   - md_done in cycle 32.
5. Simultaneous md_start_ID=1 and load_hazard=1 -> stall asserted, md_busy stays 0. Drop load_hazard next cycle with md_start_ID still 1 -> MD_WAIT entered, counter=MULT_CYCLES-1.
6. Saturation: hold load_hazard=1 for 65540 cycles -> stall_count reaches 16'hFFFF and holds. No wrap to 0.
